// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter. The frame is 1 start bit, 8 data bits sent LSB first,
// an optional parity bit, and 1 or 2 stop bits.
// The bit period is derived from CLK_FREQ / UART_BPS in the same way as uart_rx.
// uart_txd, busy and done_flag are all registered. Each one is computed from the
// next state, so the line changes on the same edge as the state change.
module uart_tx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int UART_BPS  = 115200,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       uart_txd,
    output logic       busy,
    output logic       done_flag
);

    localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam int CNT_W        = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_CNT_MAX - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    // Elaboration fails if a parameter combination cannot produce a valid frame.
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx: PARITY must be 0 (none), 1 (odd) or 2 (even)");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if (BAUD_CNT_MAX < 1) begin : g_bad_baud
        $error("uart_tx: CLK_FREQ / UART_BPS must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [2:0]       bit_cnt_next;
    logic [7:0]       shift_reg;
    logic [7:0]       shift_next;
    logic             parity_bit;
    logic             parity_next;
    logic             txd_next;
    logic             done_next;
    logic             bit_end;
    logic             accept;

    // The client may only hand over a byte in IDLE. Reset also blocks it, without
    // waiting for a clock edge.
    assign tx_ready = (state == S_IDLE) && !rst;
    assign accept   = tx_valid && tx_ready;
    assign bit_end  = (baud_cnt == BAUD_LAST);

    // State register plus the registered line outputs. All of them clear asynchronously,
    // so the line goes high as soon as rst asserts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            bit_cnt    <= 3'd0;
            shift_reg  <= 8'd0;
            parity_bit <= 1'b0;
            uart_txd   <= 1'b1;
            busy       <= 1'b0;
            done_flag  <= 1'b0;
        end else begin
            state      <= state_next;
            bit_cnt    <= bit_cnt_next;
            shift_reg  <= shift_next;
            parity_bit <= parity_next;
            uart_txd   <= txd_next;
            busy       <= (state_next != S_IDLE);
            done_flag  <= done_next;
        end
    end

    // Baud counter: runs 0..BAUD_CNT_MAX-1 during a frame and is held at 0 in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt <= '0;
        end else if (state == S_IDLE || bit_end) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
        end
    end

    // Next-state logic. The frame advances only on the last cycle of each bit period.
    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        shift_next   = shift_reg;
        parity_next  = parity_bit;
        done_next    = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next   = S_START;
                    bit_cnt_next = 3'd0;
                    shift_next   = tx_data;
                    parity_next  = (PARITY == 1) ? ~^tx_data : ^tx_data;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_next   = S_DATA;
                    bit_cnt_next = 3'd0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_next = {1'b0, shift_reg[7:1]};
                    if (bit_cnt == 3'd7) begin
                        state_next   = (PARITY != 0) ? S_PARITY : S_STOP;
                        bit_cnt_next = 3'd0;
                    end else begin
                        bit_cnt_next = bit_cnt + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_next   = S_STOP;
                    bit_cnt_next = 3'd0;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (bit_cnt == STOP_LAST) begin
                        state_next = S_IDLE;
                        done_next  = 1'b1;
                    end else begin
                        bit_cnt_next = bit_cnt + 3'd1;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Line level for the next cycle, taken from the state and data that will be current then.
    always_comb begin
        txd_next = 1'b1;
        case (state_next)
            S_IDLE:   txd_next = 1'b1;
            S_START:  txd_next = 1'b0;
            S_DATA:   txd_next = shift_next[0];
            S_PARITY: txd_next = parity_next;
            S_STOP:   txd_next = 1'b1;
            default:  txd_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx with BAUD_CNT_MAX = 10 (CLK_FREQ=1000, UART_BPS=100).
// Four instances cover these configurations:
//   0: no parity, 1 stop bit
//   1: even parity
//   2: odd parity
//   3: 2 stop bits
// Expected line patterns are hand-written. Bit i of each vector is the i-th bit period on the line.
module tb_uart_tx;

    localparam int BAUD = 10;

    logic       clk;
    logic       rst;
    logic [3:0] valid;
    logic [7:0] data [4];
    logic [3:0] ready;
    logic [3:0] txd;
    logic [3:0] busy;
    logic [3:0] done;

    int n_checks;
    int n_pass;

    uart_tx #(.CLK_FREQ(1000), .UART_BPS(100), .PARITY(0), .STOP_BITS(1)) u_p0 (
        .clk(clk), .rst(rst), .tx_data(data[0]), .tx_valid(valid[0]), .tx_ready(ready[0]),
        .uart_txd(txd[0]), .busy(busy[0]), .done_flag(done[0]));
    uart_tx #(.CLK_FREQ(1000), .UART_BPS(100), .PARITY(2), .STOP_BITS(1)) u_even (
        .clk(clk), .rst(rst), .tx_data(data[1]), .tx_valid(valid[1]), .tx_ready(ready[1]),
        .uart_txd(txd[1]), .busy(busy[1]), .done_flag(done[1]));
    uart_tx #(.CLK_FREQ(1000), .UART_BPS(100), .PARITY(1), .STOP_BITS(1)) u_odd (
        .clk(clk), .rst(rst), .tx_data(data[2]), .tx_valid(valid[2]), .tx_ready(ready[2]),
        .uart_txd(txd[2]), .busy(busy[2]), .done_flag(done[2]));
    uart_tx #(.CLK_FREQ(1000), .UART_BPS(100), .PARITY(0), .STOP_BITS(2)) u_s2 (
        .clk(clk), .rst(rst), .tx_data(data[3]), .tx_valid(valid[3]), .tx_ready(ready[3]),
        .uart_txd(txd[3]), .busy(busy[3]), .done_flag(done[3]));

    // Free-running clock with a 10-time-unit period.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    // Present a byte just after a falling edge. The accept happens on the next rising edge.
    task automatic drive_accept(input int sel, input logic [7:0] b, input string tag);
        @(negedge clk);
        data[sel]  = b;
        valid[sel] = 1'b1;
        chk({tag, "_ready_before_accept"}, 32'(ready[sel]), 32'd1);
        @(posedge clk);
    endtask

    // Walk through one frame after its accept edge and check each bit period.
    // hold=1 keeps tx_valid high so the next frame follows immediately.
    // tx_data is changed to nextd right after the accept edge in both cases.
    task automatic check_frame(input int sel, input logic [11:0] exp, input int nbits,
                               input bit hold, input logic [7:0] nextd, input string tag);
        int viol;
        int match;
        viol = 0;
        for (int i = 0; i < nbits; i++) begin
            match = 0;
            for (int c = 0; c < BAUD; c++) begin
                @(negedge clk);
                if (i == 0 && c == 0) begin
                    data[sel] = nextd;
                    if (!hold) valid[sel] = 1'b0;
                end
                if (txd[sel] === exp[i]) match++;
                if (busy[sel] !== 1'b1 || ready[sel] !== 1'b0 || done[sel] !== 1'b0) viol++;
            end
            chk($sformatf("%s_bit%0d_cycles_at_level_%0d", tag, i, exp[i]), 32'(match), 32'(BAUD));
        end
        chk({tag, "_busy_ready_done_during_frame_violations"}, 32'(viol), 32'd0);
        @(negedge clk);
        chk({tag, "_done_at_end"},  32'(done[sel]),  32'd1);
        chk({tag, "_ready_at_end"}, 32'(ready[sel]), 32'd1);
        chk({tag, "_txd_at_end"},   32'(txd[sel]),   32'd1);
        chk({tag, "_busy_at_end"},  32'(busy[sel]),  32'd0);
        if (!hold) begin
            @(negedge clk);
            chk({tag, "_done_one_cycle"}, 32'(done[sel]), 32'd0);
            chk({tag, "_txd_idle"},       32'(txd[sel]),  32'd1);
        end
    endtask

    // Directed sequence: reset, frame formats, back-to-back, mid-frame reset, random bytes.
    initial begin
        logic [7:0] b;
        clk      = 1'b0;
        rst      = 1'b1;
        valid    = 4'b0;
        n_checks = 0;
        n_pass   = 0;
        for (int k = 0; k < 4; k++) data[k] = 8'h00;

        #1;
        chk("reset_txd",   32'(txd),   32'hF);
        chk("reset_busy",  32'(busy),  32'h0);
        chk("reset_done",  32'(done),  32'h0);
        chk("reset_ready", 32'(ready), 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", 32'(ready), 32'hF);

        // 0xA5 with no parity and 1 stop bit: 0,1,0,1,0,0,1,0,1,1.
        drive_accept(0, 8'hA5, "a5_p0");
        check_frame(0, 12'b0011_0100_1010, 10, 1'b0, 8'h5A, "a5_p0");

        // Even parity: 0xA5 gives parity 0, 0x07 gives parity 1.
        drive_accept(1, 8'hA5, "a5_even");
        check_frame(1, 12'b0101_0100_1010, 11, 1'b0, 8'h00, "a5_even");
        drive_accept(1, 8'h07, "07_even");
        check_frame(1, 12'b0110_0000_1110, 11, 1'b0, 8'hFF, "07_even");

        // Odd parity: 0xA5 gives parity 1.
        drive_accept(2, 8'hA5, "a5_odd");
        check_frame(2, 12'b0111_0100_1010, 11, 1'b0, 8'h00, "a5_odd");

        // Two stop bits: 0xFF is followed by 20 cycles high.
        drive_accept(3, 8'hFF, "ff_s2");
        check_frame(3, 12'b0111_1111_1110, 11, 1'b0, 8'h00, "ff_s2");

        // tx_valid is held across two frames, and tx_data changes mid-frame.
        drive_accept(0, 8'h11, "b2b_11");
        check_frame(0, 12'b0010_0010_0010, 10, 1'b1, 8'h22, "b2b_11");
        @(posedge clk);
        check_frame(0, 12'b0010_0100_0100, 10, 1'b0, 8'h00, "b2b_22");

        // Reset at cycle 35 of a frame. 0x3C is pending with tx_valid high during reset.
        drive_accept(0, 8'h5A, "rst_mid");
        repeat (35) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_txd",  32'(txd[0]),  32'd1);
        chk("rst_mid_busy", 32'(busy[0]), 32'd0);
        chk("rst_mid_done", 32'(done[0]), 32'd0);
        data[0]  = 8'h3C;
        valid[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rst_hold%0d_ready", k), 32'(ready[0]), 32'd0);
            chk($sformatf("rst_hold%0d_txd", k),   32'(txd[0]),   32'd1);
            chk($sformatf("rst_hold%0d_done", k),  32'(done[0]),  32'd0);
        end
        rst = 1'b0;
        #1;
        chk("rst_release_ready", 32'(ready[0]), 32'd1);
        @(posedge clk);
        check_frame(0, 12'b0010_0111_1000, 10, 1'b0, 8'hC3, "after_rst_3c");

        // Random bytes with no parity: start 0, the byte LSB first, stop 1.
        for (int k = 0; k < 12; k++) begin
            b = 8'($urandom);
            drive_accept(0, b, $sformatf("rand%0d", k));
            check_frame(0, {2'b00, 1'b1, b, 1'b0}, 10, 1'b0, ~b, $sformatf("rand%0d", k));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter that serialises one byte per frame onto the serial line. Frame format: 1 start bit (low), 8 data bits LSB first, optional parity bit, 1 or 2 stop bits (high).
- Companion to the existing uart_rx receiver and uses the same baud derivation, so a uart_tx/uart_rx pair with equal parameters interoperates.
- Sits between a byte-producing client (valid/ready handshake) and the board TXD pin.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
UART_BPS, 115200, baud rate; bit period BAUD_CNT_MAX = CLK_FREQ / UART_BPS clock cycles (integer division)
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, number of stop bits; legal values 1 or 2

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-high
tx_data  input  8  byte to transmit, sampled on the accept cycle
tx_valid  input  1  client has a byte on tx_data
tx_ready  output  1  block can accept a byte this cycle
uart_txd  output  1  serial line output, registered, idles high
busy  output  1  frame in progress (START through last STOP)
done_flag  output  1  one-cycle pulse at end of frame

Behaviour:
- Reset (async, while rst=1): state=IDLE, uart_txd=1, busy=0, done_flag=0, baud counter=0, bit counter=0, shift register=0. tx_ready=0 while rst=1.
- tx_ready = (state==IDLE) && !rst; combinational from state only, never from tx_valid.
- Accept: tx_valid && tx_ready at a rising edge. On that edge:
  - tx_data is latched into the shift register.
  - Parity is computed from the latched byte: even = XOR of bits; odd = inverted XOR.
  - state moves to START.
  - tx_data/tx_valid changes after the accept edge have no effect on the frame.
- Timing: uart_txd falls in the cycle after the accept edge. Each bit drives uart_txd for exactly BAUD_CNT_MAX cycles.
- Baud counter: counts 0..BAUD_CNT_MAX-1 while state!=IDLE, wraps to 0. The bit transition occurs on the edge where the count equals BAUD_CNT_MAX-1. It is held at 0 in IDLE.
- State machine:
  - IDLE -> START on accept.
  - START -> DATA after 1 bit period.
  - DATA shifts out bits 0..7; bit counter 0..7. After bit 7: -> PARITY if PARITY!=0, else -> STOP.
  - PARITY -> STOP after 1 bit period.
  - STOP lasts STOP_BITS bit periods, then -> IDLE.
- uart_txd per state: IDLE=1, START=0, DATA=current shift-register bit (bit 0 first), PARITY=computed bit, STOP=1. uart_txd is registered and glitch-free.
- busy=1 in all states except IDLE; registered, aligned with uart_txd.
- done_flag: pulses 1 for one cycle in the first IDLE cycle after the last stop period ends. It coincides with tx_ready=1.
- Frame length: (10 + (PARITY!=0) + (STOP_BITS-1)) × BAUD_CNT_MAX cycles, measured from the first cycle of uart_txd=0 to the first IDLE cycle.
- Back-to-back frames: if tx_valid is held high, the next accept happens on the done_flag cycle. Between the last stop bit and the next start bit there is exactly 1 extra clock cycle of line high.
- Reset mid-frame: uart_txd returns to 1 immediately (async) and the frame is aborted. No done_flag is issued and no accept occurs until rst deasserts.
- tx_valid asserted while busy: ignored, tx_ready=0. The client must hold it until accepted.
- Illegal STOP_BITS or PARITY values: elaboration-time error.

Test Plan:
All scenarios use CLK_FREQ=1000, UART_BPS=100 (BAUD_CNT_MAX=10).
1. PARITY=0, STOP_BITS=1; send 0xA5 -> uart_txd reads 0,1,0,1,0,0,1,0,1,1, each level 10 cycles. First low in the cycle after accept. done_flag pulses once 100 cycles after the start edge.
2. PARITY=2 (even), send 0xA5 -> parity bit 0; send 0x07 -> parity bit 1. Frame length is 110 cycles. With PARITY=1, send 0xA5 -> parity bit 1.
3. STOP_BITS=2, send 0xFF -> line high for 20 cycles after bit 7. done_flag arrives at 110 cycles.
4. tx_valid held high with 0x11 then 0x22 -> two frames separated by exactly 1 extra high cycle. tx_ready=0 throughout each frame. Changing tx_data mid-frame does not alter the bits on the line.
5. Assert rst at cycle 35 of a frame -> uart_txd=1 and busy=0 immediately, no done_flag. After deassert, a new 0x3C frame transmits correctly.
6. Loopback to uart_rx with matching CLK_FREQ/UART_BPS, 256 random bytes, PARITY=0 -> every byte is received equal to the byte sent, with frame_error=0.
